// File: rtl/cy_mux_scanner_pkg.sv
// Shared types and constants for the cy_mux scanner: FSM state encoding,
// select/counter widths and the helper that picks the per-channel entry state.
package cy_mux_scanner_pkg;

  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  // A zero settle time skips the wait state entirely and samples on the next edge.
  function automatic state_e scan_entry(input int unsigned settle);
    if (settle == 32'd0) begin
      return ST_SAMPLE;
    end else begin
      return ST_SETTLE;
    end
  endfunction

endpackage

// File: rtl/cy_mux_scanner_if.sv
// Parallel frame output of the scanner: data word with a valid/ready handshake.
// The scanner is the master (producer); the consumer uses the slave modport.
interface cy_mux_scanner_if #(
  parameter int NUM_CH = 8
) ();
  logic [NUM_CH-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cy_settle_cnt.sv
// Loadable down-counter that times the settle wait after each select change.
// 'last' flags the final wait cycle so the FSM can move to SAMPLE on that edge.
module cy_settle_cnt
  import cy_mux_scanner_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count: load wins over decrement, decrement saturates at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register, reset to the settle reload value
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= load_val;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q <= 4'd1);

endmodule

// File: rtl/cy_mux_scanner.sv
// Scans NUM_CH mux channels: drives sel, waits SETTLE cycles, samples mux_y,
// and presents the assembled frame on a valid/ready handshake.
module cy_mux_scanner
  import cy_mux_scanner_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [SEL_W-1:0]  sel,
  input  logic              mux_y,
  output logic              busy,
  output logic              overrun,
  cy_mux_scanner_if.master  out_if
);

  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic [NUM_CH-1:0] sample_word;
  logic              frame_done;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_last;

  cy_settle_cnt u_settle_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (SETTLE_VAL),
    .last     (cnt_last)
  );

  // shadow with the bit for the current channel replaced by the live mux output
  always_comb begin
    sample_word = shadow_q;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sel_q == SEL_W'(i)) begin
        sample_word[i] = mux_y;
      end else begin
        sample_word[i] = shadow_q[i];
      end
    end
  end

  // FSM next state, select walk and frame/handshake bookkeeping
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    frame_done = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;

    if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        sel_d = 3'd0;
        if (start) begin
          state_d  = scan_entry(SETTLE);
          cnt_load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      ST_SAMPLE: begin
        shadow_d = sample_word;
        cnt_load = 1'b1;
        if (sel_q == LAST_SEL) begin
          frame_done = 1'b1;
          sel_d      = 3'd0;
          if (CONTINUOUS != 32'd0) begin
            state_d = scan_entry(SETTLE);
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          sel_d   = sel_q + 3'd1;
          state_d = scan_entry(SETTLE);
        end
      end
      ST_HOLD: begin
        if (valid_q && out_if.ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An unaccepted frame is never overwritten; the new one is dropped instead.
    if (frame_done) begin
      if (!valid_q || out_if.ready) begin
        data_d  = sample_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // state and output registers; reset abandons any frame in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sel_q     <= 3'd0;
      shadow_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign sel          = sel_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;

endmodule

// File: tb/tb_cy_mux_scanner.sv
// Self-checking bench: three scanner instances (SETTLE=1 one-shot, SETTLE=0
// one-shot, SETTLE=1 continuous), each fed by a behavioural 8:1 mux model.
module tb_cy_mux_scanner;

  logic clk;
  logic [2:0]      rst_r;
  logic [2:0]      start_r;
  logic [2:0]      ready_r;
  logic [2:0][7:0] mux_in;
  wire  [2:0][2:0] sel_w;
  wire  [2:0][7:0] data_w;
  wire  [2:0]      valid_w;
  wire  [2:0]      busy_w;
  wire  [2:0]      ovr_w;
  wire  [2:0]      y_w;

  int total;
  int bad;
  logic [7:0] sb_q[$];

  cy_mux_scanner_if #(.NUM_CH(8)) if_a ();
  cy_mux_scanner_if #(.NUM_CH(8)) if_b ();
  cy_mux_scanner_if #(.NUM_CH(8)) if_c ();

  assign if_a.ready = ready_r[0];
  assign if_b.ready = ready_r[1];
  assign if_c.ready = ready_r[2];
  assign data_w[0]  = if_a.data;
  assign data_w[1]  = if_b.data;
  assign data_w[2]  = if_c.data;
  assign valid_w[0] = if_a.valid;
  assign valid_w[1] = if_b.valid;
  assign valid_w[2] = if_c.valid;

  assign y_w[0] = mux_in[0][sel_w[0]];
  assign y_w[1] = mux_in[1][sel_w[1]];
  assign y_w[2] = mux_in[2][sel_w[2]];

  cy_mux_scanner #(.NUM_CH(8), .SETTLE(1), .CONTINUOUS(0)) u_a (
    .clock(clk), .reset(rst_r[0]), .start(start_r[0]), .sel(sel_w[0]),
    .mux_y(y_w[0]), .busy(busy_w[0]), .overrun(ovr_w[0]), .out_if(if_a)
  );
  cy_mux_scanner #(.NUM_CH(8), .SETTLE(0), .CONTINUOUS(0)) u_b (
    .clock(clk), .reset(rst_r[1]), .start(start_r[1]), .sel(sel_w[1]),
    .mux_y(y_w[1]), .busy(busy_w[1]), .overrun(ovr_w[1]), .out_if(if_b)
  );
  cy_mux_scanner #(.NUM_CH(8), .SETTLE(1), .CONTINUOUS(1)) u_c (
    .clock(clk), .reset(rst_r[2]), .start(start_r[2]), .sel(sel_w[2]),
    .mux_y(y_w[2]), .busy(busy_w[2]), .overrun(ovr_w[2]), .out_if(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start one frame on instance d and wait for valid; checks sel walk, latency, data.
  task automatic scan_once(input int d, input int settle, input bit chk_sel,
                           output logic [7:0] got);
    int cyc;
    logic [7:0] exp;
    sb_q.push_back(mux_in[d]);
    start_r[d] = 1'b1;
    step();
    start_r[d] = 1'b0;
    cyc = 0;
    while (valid_w[d] !== 1'b1 && cyc < 100) begin
      if (chk_sel) begin
        total++;
        if (sel_w[d] !== 3'(cyc / (settle + 1))) begin
          bad++;
          $display("FAIL sel_walk dut%0d cyc=%0d got=%0d exp=%0d", d, cyc, sel_w[d], cyc / (settle + 1));
        end
      end
      step();
      cyc++;
    end
    total++;
    if (cyc != 8 * (settle + 1)) begin
      bad++;
      $display("FAIL latency dut%0d got=%0d exp=%0d", d, cyc, 8 * (settle + 1));
    end
    exp = sb_q.pop_front();
    total++;
    if (data_w[d] !== exp) begin
      bad++;
      $display("FAIL frame_data dut%0d got=%h exp=%h", d, data_w[d], exp);
    end
    total++;
    if (sel_w[d] !== 3'd0) begin
      bad++;
      $display("FAIL sel_wrap dut%0d got=%0d exp=0", d, sel_w[d]);
    end
    got = exp;
  endtask

  task automatic test_reset();
    rst_r   = 3'b111;
    start_r = 3'b000;
    ready_r = 3'b000;
    mux_in  = '0;
    step();
    step();
    rst_r = 3'b000;
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({sel_w[d], data_w[d], valid_w[d], busy_w[d], ovr_w[d]} !== 14'd0) begin
        bad++;
        $display("FAIL reset_state dut%0d got sel=%0d data=%h v=%b b=%b o=%b exp all 0",
                 d, sel_w[d], data_w[d], valid_w[d], busy_w[d], ovr_w[d]);
      end
    end
  endtask

  task automatic test_frame();
    logic [7:0] got;
    mux_in[0]  = 8'hB2;
    ready_r[0] = 1'b1;
    scan_once(0, 1, 1'b1, got);
    step();
    total++;
    if ({valid_w[0], busy_w[0], ovr_w[0]} !== 3'b000) begin
      bad++;
      $display("FAIL frame_accept got v=%b b=%b o=%b exp 000", valid_w[0], busy_w[0], ovr_w[0]);
    end
  endtask

  task automatic test_settle0();
    logic [7:0] got;
    mux_in[1]  = 8'h5A;
    ready_r[1] = 1'b1;
    scan_once(1, 0, 1'b1, got);
    step();
    total++;
    if ({valid_w[1], busy_w[1]} !== 2'b00) begin
      bad++;
      $display("FAIL settle0_accept got v=%b b=%b exp 00", valid_w[1], busy_w[1]);
    end
  endtask

  task automatic test_hold();
    logic [7:0] got;
    ready_r[0] = 1'b0;
    mux_in[0]  = 8'h3C;
    scan_once(0, 1, 1'b0, got);
    mux_in[0]  = 8'hFF;
    start_r[0] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (valid_w[0] !== 1'b1 || data_w[0] !== got || busy_w[0] !== 1'b1) begin
        bad++;
        $display("FAIL hold k=%0d got v=%b data=%h b=%b exp v=1 data=%h b=1",
                 k, valid_w[0], data_w[0], busy_w[0], got);
      end
    end
    start_r[0] = 1'b0;
    ready_r[0] = 1'b1;
    step();
    step();
    total++;
    if ({valid_w[0], busy_w[0], sel_w[0]} !== 5'd0) begin
      bad++;
      $display("FAIL hold_release got v=%b b=%b sel=%0d exp 0 0 0", valid_w[0], busy_w[0], sel_w[0]);
    end
  endtask

  task automatic test_continuous();
    logic [7:0] got;
    logic [7:0] exp;
    int ovr_cnt;
    int cyc;
    ready_r[2] = 1'b0;
    mux_in[2]  = 8'hB2;
    scan_once(2, 1, 1'b0, got);
    // second frame reads 8'hFF but must be dropped with one overrun pulse
    mux_in[2] = 8'hFF;
    ovr_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (ovr_w[2] === 1'b1) ovr_cnt++;
      total++;
      if (valid_w[2] !== 1'b1 || data_w[2] !== got || busy_w[2] !== 1'b1) begin
        bad++;
        $display("FAIL cont_hold k=%0d got v=%b data=%h b=%b exp v=1 data=%h b=1",
                 k, valid_w[2], data_w[2], busy_w[2], got);
      end
    end
    total++;
    if (ovr_cnt != 1) begin
      bad++;
      $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt);
    end
    // third frame completes on the very edge the old one is accepted
    sb_q.push_back(8'hFF);
    ovr_cnt = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (ovr_w[2] === 1'b1) ovr_cnt++;
    end
    ready_r[2] = 1'b1;
    step();
    if (ovr_w[2] === 1'b1) ovr_cnt++;
    exp = sb_q.pop_front();
    total++;
    if (valid_w[2] !== 1'b1 || data_w[2] !== exp || ovr_cnt != 0) begin
      bad++;
      $display("FAIL cont_same_edge got v=%b data=%h ovr=%0d exp v=1 data=%h ovr=0",
               valid_w[2], data_w[2], ovr_cnt, exp);
    end
    mux_in[2] = 8'h0F;
    sb_q.push_back(8'h0F);
    step();
    ready_r[2] = 1'b0;
    total++;
    if (valid_w[2] !== 1'b0) begin
      bad++;
      $display("FAIL cont_accept got v=%b exp v=0", valid_w[2]);
    end
    cyc = 0;
    ovr_cnt = 0;
    while (valid_w[2] !== 1'b1 && cyc < 40) begin
      step();
      if (ovr_w[2] === 1'b1) ovr_cnt++;
      cyc++;
    end
    exp = sb_q.pop_front();
    total++;
    if (cyc != 15 || data_w[2] !== exp || ovr_cnt != 0) begin
      bad++;
      $display("FAIL cont_next got cyc=%0d data=%h ovr=%0d exp cyc=15 data=%h ovr=0",
               cyc, data_w[2], ovr_cnt, exp);
    end
    rst_r[2] = 1'b1;
    step();
    rst_r[2] = 1'b0;
    total++;
    if ({valid_w[2], busy_w[2], sel_w[2]} !== 5'd0) begin
      bad++;
      $display("FAIL cont_reset got v=%b b=%b sel=%0d exp 0 0 0", valid_w[2], busy_w[2], sel_w[2]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    int cyc;
    ready_r[0] = 1'b1;
    mux_in[0]  = 8'hB2;
    start_r[0] = 1'b1;
    step();
    start_r[0] = 1'b0;
    cyc = 0;
    while (sel_w[0] !== 3'd5 && cyc < 50) begin
      step();
      cyc++;
    end
    total++;
    if (sel_w[0] !== 3'd5) begin
      bad++;
      $display("FAIL reach_sel5 got sel=%0d exp 5", sel_w[0]);
    end
    rst_r[0]   = 1'b1;
    start_r[0] = 1'b1;
    step();
    rst_r[0]   = 1'b0;
    start_r[0] = 1'b0;
    total++;
    if ({sel_w[0], data_w[0], valid_w[0], busy_w[0], ovr_w[0]} !== 14'd0) begin
      bad++;
      $display("FAIL mid_reset got sel=%0d data=%h v=%b b=%b o=%b exp all 0",
               sel_w[0], data_w[0], valid_w[0], busy_w[0], ovr_w[0]);
    end
    mux_in[0] = 8'h96;
    scan_once(0, 1, 1'b1, got);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_frame();
    test_settle0();
    test_hold();
    test_continuous();
    test_reset_mid();
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
